flag_hazard_ctrl: RTL

FLAG_HAZARD_CTRL -- requirements
Module: flag_hazard_ctrl

---
 rtl/flag_hazard_ctrl.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/flag_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// flag_hazard_ctrl
//
// Tracks in-flight flag writers in a short EX/MEM/WB pipeline so that a
// conditional branch in decode sees correctly forwarded condition flags.
//
// Flag vectors are ordered {N, V, Z} (bit 2 = N, bit 1 = V, bit 0 = Z).
//
// Ports
//   clk                : sole clock, all state changes on the rising edge
//   rst                : asynchronous, active-low reset
//   id_flags_set [1:0] : flag-write class of the decode instruction
//                        11 = write N,V,Z   01 = write Z only   00/10 = none
//   id_is_branch       : decode instruction is a conditional branch
//   id_cond      [2:0] : branch condition code of the decode instruction
//   ex_flags_from_alu  : ALU flags produced by the EX-stage instruction
//   rf_flags     [2:0] : committed flags from the flag register
//   stall_in           : external freeze, every slot holds
//   flush              : kill the EX and MEM instructions, WB still commits
//   wb_flags_set [1:0] : write class presented to the flag register
//   wb_flags     [2:0] : flag values presented to the flag register
//   stall_out          : decode hold request (branch behind an EX writer)
//   branch_valid       : the decode branch resolves this cycle
//   branch_taken       : branch outcome, meaningful while branch_valid = 1
// -----------------------------------------------------------------------------
module flag_hazard_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] id_flags_set,
  input  logic       id_is_branch,
  input  logic [2:0] id_cond,
  input  logic [2:0] ex_flags_from_alu,
  input  logic [2:0] rf_flags,
  input  logic       stall_in,
  input  logic       flush,
  output logic [1:0] wb_flags_set,
  output logic [2:0] wb_flags,
  output logic       stall_out,
  output logic       branch_valid,
  output logic       branch_taken
);

  // Write-class encodings
  localparam logic [1:0] SET_NONE = 2'b00;
  localparam logic [1:0] SET_Z    = 2'b01;
  localparam logic [1:0] SET_ALL  = 2'b11;

  // Branch condition codes
  localparam logic [2:0] COND_NE = 3'b000;
  localparam logic [2:0] COND_EQ = 3'b001;
  localparam logic [2:0] COND_GT = 3'b010;
  localparam logic [2:0] COND_LT = 3'b011;
  localparam logic [2:0] COND_GE = 3'b100;
  localparam logic [2:0] COND_LE = 3'b101;
  localparam logic [2:0] COND_OV = 3'b110;

  // ---------------------------------------------------------------------------
  // Tracker slots. The EX slot never carries flags: its flags are still being
  // computed by the ALU and are sampled from ex_flags_from_alu as the
  // instruction moves into MEM.
  // ---------------------------------------------------------------------------
  logic       ex_valid_q,  ex_valid_d;
  logic [1:0] ex_set_q,    ex_set_d;
  logic       mem_valid_q, mem_valid_d;
  logic [1:0] mem_set_q,   mem_set_d;
  logic [2:0] mem_flags_q, mem_flags_d;
  logic       wb_valid_q,  wb_valid_d;
  logic [1:0] wb_set_q,    wb_set_d;
  logic [2:0] wb_flags_q,  wb_flags_d;

  logic [2:0] eff_flags;

  // Class 10 carries no write; fold it into 00 so downstream slots only ever
  // hold 00, 01 or 11.
  function automatic logic [1:0] norm_set(input logic [1:0] set);
    return (set == 2'b10) ? SET_NONE : set;
  endfunction

  // Apply one in-flight writer on top of a flag vector.
  function automatic logic [2:0] overlay(
    input logic [2:0] base,
    input logic       valid,
    input logic [1:0] set,
    input logic [2:0] flags
  );
    logic [2:0] res;
    res = base;
    if (valid) begin
      if (set == SET_ALL) begin
        res = flags;
      end else if (set == SET_Z) begin
        res[0] = flags[0];
      end
    end
    return res;
  endfunction

  // Evaluate a condition code against {N, V, Z}.
  function automatic logic cond_met(input logic [2:0] cond, input logic [2:0] f);
    logic n;
    logic v;
    logic z;
    logic res;
    n = f[2];
    v = f[1];
    z = f[0];
    case (cond)
      COND_NE: res = ~z;
      COND_EQ: res = z;
      COND_GT: res = ~z & ~n;
      COND_LT: res = n;
      COND_GE: res = z | ~n;
      COND_LE: res = n | z;
      COND_OV: res = v;
      default: res = 1'b1;  // unconditional
    endcase
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // Hazard detection and branch resolution.
  //
  // A branch behind an EX-stage writer must wait: the EX flags are not
  // forwarded, so one bubble lets the writer reach MEM where its flags are
  // visible. The rst term keeps the decode-facing outputs quiet while the
  // block is held in reset, independent of what decode presents.
  // ---------------------------------------------------------------------------
  always_comb begin
    stall_out    = rst & id_is_branch & ex_valid_q & (ex_set_q != SET_NONE);
    branch_valid = rst & id_is_branch & ~stall_out & ~stall_in;

    // Older writer first, younger writer last so the youngest value wins.
    eff_flags    = overlay(rf_flags, wb_valid_q, wb_set_q, wb_flags_q);
    eff_flags    = overlay(eff_flags, mem_valid_q, mem_set_q, mem_flags_q);
    branch_taken = cond_met(id_cond, eff_flags);
  end

  // Flag register write port comes straight from the WB slot. While frozen,
  // the same write is re-presented, which is harmless because it rewrites
  // identical values.
  always_comb begin
    wb_flags_set = wb_valid_q ? wb_set_q : SET_NONE;
    wb_flags     = wb_flags_q;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic for the tracker slots.
  // ---------------------------------------------------------------------------
  always_comb begin
    ex_valid_d  = ex_valid_q;
    ex_set_d    = ex_set_q;
    mem_valid_d = mem_valid_q;
    mem_set_d   = mem_set_q;
    mem_flags_d = mem_flags_q;
    wb_valid_d  = wb_valid_q;
    wb_set_d    = wb_set_q;
    wb_flags_d  = wb_flags_q;

    if (!stall_in) begin
      // WB always advances from MEM, even on a flush: that instruction is
      // older than the one causing the flush and must still commit.
      wb_valid_d = mem_valid_q;
      wb_set_d   = mem_set_q;
      wb_flags_d = mem_flags_q;

      if (flush) begin
        ex_valid_d  = 1'b0;
        ex_set_d    = SET_NONE;
        mem_valid_d = 1'b0;
        mem_set_d   = SET_NONE;
        mem_flags_d = 3'b000;
      end else begin
        mem_valid_d = ex_valid_q;
        mem_set_d   = ex_set_q;
        mem_flags_d = ex_flags_from_alu;

        if (stall_out) begin
          // Decode is held; insert a bubble behind the writer.
          ex_valid_d = 1'b0;
          ex_set_d   = SET_NONE;
        end else begin
          ex_valid_d = 1'b1;
          ex_set_d   = norm_set(id_flags_set);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers. Reset discards every pending write; the flag register
  // itself is cleared by the same reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid_q  <= 1'b0;
      ex_set_q    <= SET_NONE;
      mem_valid_q <= 1'b0;
      mem_set_q   <= SET_NONE;
      mem_flags_q <= 3'b000;
      wb_valid_q  <= 1'b0;
      wb_set_q    <= SET_NONE;
      wb_flags_q  <= 3'b000;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_set_q    <= ex_set_d;
      mem_valid_q <= mem_valid_d;
      mem_set_q   <= mem_set_d;
      mem_flags_q <= mem_flags_d;
      wb_valid_q  <= wb_valid_d;
      wb_set_q    <= wb_set_d;
      wb_flags_q  <= wb_flags_d;
    end
  end

endmodule
